// File: rtl/wb_stage_buf_pkg.sv
// Shared types for the memory-to-writeback stage: state encoding, entry record, default widths.
package wb_stage_buf_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DST_W  = 4;
    localparam int DEF_CNT_W  = 16;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } wb_state_e;

    typedef struct packed {
        logic                  write_reg;
        logic [DEF_DST_W-1:0]  dst;
        logic [DEF_DATA_W-1:0] data;
    } wb_entry_t;

    // Register 0 is hard-wired when zero_ro is set, so a write to it is dropped.
    function automatic logic load_write_reg(input logic wr, input logic dst_is_zero,
                                            input logic zero_ro);
        return wr & ~(zero_ro & dst_is_zero);
    endfunction

endpackage

// File: rtl/wb_stage_buf_fwd_match.sv
// One forwarding lookup: compares an operand index against the head and skid entries.
module wb_fwd_match
    import wb_stage_buf_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DST_W  = DEF_DST_W
) (
    input  logic [DST_W-1:0]  src,
    input  logic              h_valid,
    input  logic              h_wr,
    input  logic [DST_W-1:0]  h_dst,
    input  logic [DATA_W-1:0] h_data,
    input  logic              s_valid,
    input  logic              s_wr,
    input  logic [DST_W-1:0]  s_dst,
    input  logic [DATA_W-1:0] s_data,
    output logic              hit,
    output logic [DATA_W-1:0] data
);
    logic h_hit, s_hit;

    always_comb begin
        h_hit = h_valid & h_wr & (h_dst == src);
        s_hit = s_valid & s_wr & (s_dst == src);
        hit   = h_hit | s_hit;
        // The skid entry is younger, so it wins when both match.
        if (s_hit)      data = s_data;
        else if (h_hit) data = h_data;
        else            data = '0;
    end
endmodule

// File: rtl/wb_stage_buf.sv
// Memory-to-writeback stage with a 2-entry skid buffer, flush and retired-write counter.
// Optional forwarding lookup is enabled by defining WB_STAGE_FWD_EN.
module wb_stage_buf
    import wb_stage_buf_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int DST_W       = DEF_DST_W,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int ZERO_REG_RO = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              valid_m,
    output logic              ready_m,
    input  logic              writeReg_m,
    input  logic [DST_W-1:0]  dst_m,
    input  logic [DATA_W-1:0] regData_m,
    output logic              valid_w,
    input  logic              ready_w,
    output logic              writeReg_w,
    output logic [DST_W-1:0]  dst_w,
    output logic [DATA_W-1:0] regData_w,
    output logic [CNT_W-1:0]  retire_cnt,
    input  logic [DST_W-1:0]  fwd_src_a,
    input  logic [DST_W-1:0]  fwd_src_b,
    output logic              fwd_hit_a,
    output logic              fwd_hit_b,
    output logic [DATA_W-1:0] fwd_data_a,
    output logic [DATA_W-1:0] fwd_data_b
);
    typedef struct packed {
        logic              wr;
        logic [DST_W-1:0]  dst;
        logic [DATA_W-1:0] data;
    } entry_t;

    wb_state_e        state_q, state_d;
    entry_t           h_q, h_d, s_q, s_d, in_e;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept, pop;

    assign ready_m    = (state_q != ST_TWO);
    assign valid_w    = (state_q != ST_EMPTY);
    assign writeReg_w = h_q.wr;
    assign dst_w      = h_q.dst;
    assign regData_w  = h_q.data;
    assign retire_cnt = cnt_q;

    always_comb begin
        accept    = valid_m & ready_m;
        pop       = valid_w & ready_w;
        in_e.wr   = load_write_reg(writeReg_m, (dst_m == '0), (ZERO_REG_RO != 0));
        in_e.dst  = dst_m;
        in_e.data = regData_m;

        state_d = state_q;
        h_d     = h_q;
        s_d     = s_q;
        // A pop in a flush cycle still retires, so the counter ignores flush.
        cnt_d   = (pop && h_q.wr) ? cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : cnt_q;

        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (accept) begin
                    h_d     = in_e;
                    state_d = ST_ONE;
                end
                ST_ONE: begin
                    if (accept && pop) begin
                        h_d = in_e;
                    end else if (accept) begin
                        s_d     = in_e;
                        state_d = ST_TWO;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: if (pop) begin
                    h_d     = s_q;
                    state_d = ST_ONE;
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            h_q     <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef WB_STAGE_FWD_EN
    wb_fwd_match #(.DATA_W(DATA_W), .DST_W(DST_W)) u_fwd_a (
        .src(fwd_src_a),
        .h_valid(valid_w), .h_wr(h_q.wr), .h_dst(h_q.dst), .h_data(h_q.data),
        .s_valid(state_q == ST_TWO), .s_wr(s_q.wr), .s_dst(s_q.dst), .s_data(s_q.data),
        .hit(fwd_hit_a), .data(fwd_data_a)
    );
    wb_fwd_match #(.DATA_W(DATA_W), .DST_W(DST_W)) u_fwd_b (
        .src(fwd_src_b),
        .h_valid(valid_w), .h_wr(h_q.wr), .h_dst(h_q.dst), .h_data(h_q.data),
        .s_valid(state_q == ST_TWO), .s_wr(s_q.wr), .s_dst(s_q.dst), .s_data(s_q.data),
        .hit(fwd_hit_b), .data(fwd_data_b)
    );
`else
    logic unused_fwd_src;
    assign unused_fwd_src = ^{fwd_src_a, fwd_src_b};
    assign fwd_hit_a      = 1'b0;
    assign fwd_hit_b      = 1'b0;
    assign fwd_data_a     = '0;
    assign fwd_data_b     = '0;
`endif
endmodule

// File: tb/tb_wb_stage_buf.sv
// Scoreboard bench for wb_stage_buf: directed stimulus, monitor checks every retired entry.
module tb_wb_stage_buf;
    logic       clk = 1'b0;
    logic       rst, flush, valid_m, ready_m, writeReg_m, ready_w;
    logic [3:0] dst_m, dst_w, fwd_src_a, fwd_src_b;
    logic [7:0] regData_m, regData_w, fwd_data_a, fwd_data_b;
    logic       valid_w, writeReg_w, fwd_hit_a, fwd_hit_b;
    logic [3:0] retire_cnt;

    typedef struct {
        logic       wr;
        logic [3:0] dst;
        logic [7:0] data;
    } ent_t;

    ent_t q[$];
    int   exp_cnt = 0;
    int   n_pass  = 0;
    int   n_total = 0;

    wb_stage_buf #(.DATA_W(8), .DST_W(4), .CNT_W(4), .ZERO_REG_RO(1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .valid_m(valid_m), .ready_m(ready_m), .writeReg_m(writeReg_m),
        .dst_m(dst_m), .regData_m(regData_m),
        .valid_w(valid_w), .ready_w(ready_w), .writeReg_w(writeReg_w),
        .dst_w(dst_w), .regData_w(regData_w), .retire_cnt(retire_cnt),
        .fwd_src_a(fwd_src_a), .fwd_src_b(fwd_src_b),
        .fwd_hit_a(fwd_hit_a), .fwd_hit_b(fwd_hit_b),
        .fwd_data_a(fwd_data_a), .fwd_data_b(fwd_data_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic wr, input logic [3:0] d, input logic [7:0] x);
        valid_m    = v;
        writeReg_m = wr;
        dst_m      = d;
        regData_m  = x;
    endtask

    // Monitor/scoreboard: sampled on the falling edge, describing the coming rising edge.
    always @(negedge clk) begin
        ent_t e;
        if (rst) begin
            q.delete();
            exp_cnt = 0;
        end else begin
            if (valid_w && ready_w) begin
                if (q.size() == 0) begin
                    check("sb_unexpected_pop", q.size(), 1);
                end else begin
                    e = q.pop_front();
                    check("sb_wr", writeReg_w, e.wr);
                    check("sb_dst", dst_w, e.dst);
                    check("sb_data", regData_w, e.data);
                    if (e.wr) exp_cnt = (exp_cnt + 1) % 16;
                end
            end
            if (flush) begin
                q.delete();
            end else if (valid_m && ready_m) begin
                e.wr   = writeReg_m && (dst_m != 4'd0);
                e.dst  = dst_m;
                e.data = regData_m;
                q.push_back(e);
            end
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0; ready_w = 1'b0;
        fwd_src_a = 4'd0; fwd_src_b = 4'd0;
        offer(1'b0, 1'b0, 4'd0, 8'd0);
        step(); step();
        check("rst_valid_w", valid_w, 0);
        check("rst_wr_w", writeReg_w, 0);
        check("rst_dst_w", dst_w, 0);
        check("rst_data_w", regData_w, 0);
        check("rst_cnt", retire_cnt, 0);
        check("rst_ready_m", ready_m, 1);
        check("rst_fwd", {fwd_hit_a, fwd_hit_b, fwd_data_a, fwd_data_b}, 0);
        rst = 1'b0;

        // Streaming, one entry per cycle with one-cycle latency.
        ready_w = 1'b1;
        offer(1'b1, 1'b1, 4'd1, 8'h11); step();
        check("lat_data_11", regData_w, 8'h11);
        offer(1'b1, 1'b1, 4'd2, 8'h22); step();
        check("lat_data_22", regData_w, 8'h22);
        offer(1'b1, 1'b1, 4'd3, 8'h33); step();
        check("lat_dst_3", dst_w, 3);
        offer(1'b0, 1'b0, 4'd0, 8'd0); step();
        check("stream_cnt", retire_cnt, 3);
        check("stream_empty", valid_w, 0);

        // Backpressure: skid fills, outputs hold, drains in order.
        ready_w = 1'b0;
        offer(1'b1, 1'b1, 4'd4, 8'h44); step();
        check("one_ready_m", ready_m, 1);
        offer(1'b1, 1'b1, 4'd5, 8'h55); step();
        check("two_ready_m", ready_m, 0);
        offer(1'b0, 1'b0, 4'd0, 8'd0); step();
        check("hold_data", regData_w, 8'h44);
        check("hold_dst", dst_w, 4);
        ready_w = 1'b1; step();
        check("drain_ready_m", ready_m, 1);
        check("drain_data", regData_w, 8'h55);
        step();
        check("drain_cnt", retire_cnt, 5);

        // Writes to register 0 are dropped.
        offer(1'b1, 1'b1, 4'd0, 8'hAA); step();
        check("zr_wr_w", writeReg_w, 0);
        check("zr_data", regData_w, 8'hAA);
        offer(1'b0, 1'b0, 4'd0, 8'd0); step();
        check("zr_cnt", retire_cnt, 5);

        // Fill to TWO with same destination, probe forwarding, then flush.
        ready_w = 1'b0;
        offer(1'b1, 1'b1, 4'd5, 8'h10); step();
        offer(1'b1, 1'b1, 4'd5, 8'h20); step();
        offer(1'b0, 1'b0, 4'd0, 8'd0);
        fwd_src_a = 4'd5; fwd_src_b = 4'd6; #1;
`ifdef WB_STAGE_FWD_EN
        check("fwd_hit_a", fwd_hit_a, 1);
        check("fwd_data_a", fwd_data_a, 8'h20);
        check("fwd_hit_b", fwd_hit_b, 0);
        check("fwd_data_b", fwd_data_b, 0);
`else
        check("fwd_off_a", {fwd_hit_a, fwd_data_a}, 0);
        check("fwd_off_b", {fwd_hit_b, fwd_data_b}, 0);
`endif
        flush = 1'b1;
        offer(1'b1, 1'b1, 4'd9, 8'h99); step();
        flush = 1'b0;
        offer(1'b0, 1'b0, 4'd0, 8'd0);
        check("flush_valid_w", valid_w, 0);
        check("flush_ready_m", ready_m, 1);
        step();
        check("flush_dropped", valid_w, 0);
        check("flush_cnt", retire_cnt, 5);

        // Counter wrap: 11 more writes take it from 5 to 16 = 0 mod 16.
        ready_w = 1'b1;
        for (int i = 0; i < 11; i++) begin
            offer(1'b1, 1'b1, 4'(i + 1), 8'(8'h60 + i)); step();
        end
        offer(1'b0, 1'b0, 4'd0, 8'd0); step();
        check("wrap_cnt", retire_cnt, 0);
        check("wrap_model", retire_cnt, exp_cnt[3:0]);

        // Reset in the middle of a stream.
        ready_w = 1'b0;
        offer(1'b1, 1'b1, 4'd7, 8'h71); step();
        offer(1'b1, 1'b1, 4'd8, 8'h82); step();
        rst = 1'b1; step();
        rst = 1'b0;
        offer(1'b0, 1'b0, 4'd0, 8'd0);
        check("mrst_outs", {valid_w, writeReg_w, dst_w, regData_w, retire_cnt}, 0);
        check("mrst_ready_m", ready_m, 1);
        ready_w = 1'b1;
        offer(1'b1, 1'b1, 4'd3, 8'h3C); step();
        offer(1'b0, 1'b0, 4'd0, 8'd0);
        check("post_rst_data", regData_w, 8'h3C);
        step();
        check("post_rst_cnt", retire_cnt, 1);
        check("sb_drained", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
